// File: rtl/spi_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package  : spi_pkg                                               |
// | Purpose  : Shared types and helpers for the spi_xfer SPI master  |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
package spi_pkg;

  // Transfer controller states
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SETUP     = 3'd1,
    SHIFT     = 3'd2,
    HOLD      = 3'd3,
    IDLE_HELD = 3'd4
  } state_e;

  // SPI modes encoded as {CPOL, CPHA}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  // Width of a counter that must reach the value w
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_shifter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : spi_shifter                                           |
// | Purpose  : Parallel-load bidirectional shift register; one bit   |
// |            leaves at one end while a new bit enters the other.   |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module spi_shifter #(
  parameter int WIDTH      = 8,
  parameter bit SHIFT_LEFT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_data_i,
  input  logic             shift_i,
  input  logic             shift_in_i,
  output logic [WIDTH-1:0] data_o,
  output logic             shift_out_o
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] shifted;

  generate
    if (SHIFT_LEFT) begin : g_left
      assign shifted     = {data_q[WIDTH-2:0], shift_in_i};
      assign shift_out_o = data_q[WIDTH-1];
    end else begin : g_right
      assign shifted     = {shift_in_i, data_q[WIDTH-1:1]};
      assign shift_out_o = data_q[0];
    end
  endgenerate

  // Load has priority over shift; otherwise hold
  always_comb begin
    data_d = data_q;
    if (load_i) begin
      data_d = load_data_i;
    end else if (shift_i) begin
      data_d = shifted;
    end
  end

  // Register update
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule
`default_nettype wire

// File: rtl/spi_xfer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : spi_xfer                                              |
// | Purpose  : Full-duplex SPI master, any mode, MSB/LSB first,      |
// |            bit rate set by an external half-bit tick.            |
// | Options  : SPI_XFER_CS_HOLD_EN adds cs_hold_i to keep cs_n low   |
// |            between consecutive words.                            |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module spi_xfer
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter bit CPOL       = 1'b0,
  parameter bit CPHA       = 1'b0,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_en_i,
`ifdef SPI_XFER_CS_HOLD_EN
  input  logic                  cs_hold_i,
`endif
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  done_o,
  output logic                  busy_o,
  output logic                  sclk_o,
  output logic                  mosi_o,
  input  logic                  miso_i,
  output logic                  cs_n_o
);

  localparam int CW = cnt_width(DATA_WIDTH);
  // Sample count already reached when the final trailing edge occurs
  localparam logic [CW-1:0] LAST_CNT = CPHA ? CW'(DATA_WIDTH - 1) : CW'(DATA_WIDTH);

  state_e                state_q;
  logic                  sclk_q;
  logic                  cs_n_q;
  logic                  mosi_q;
  logic                  done_q;
  logic                  busy_q;
  logic                  phase_q;   // 0 = next edge is leading, 1 = trailing
  logic [CW-1:0]         cnt_q;
  logic [DATA_WIDTH-1:0] rx_data_q;

  logic                  accept;
  logic                  lead_tick;
  logic                  trail_tick;
  logic                  last_trail;
  logic                  sample_tick;
  logic                  drive_tick;
  logic                  first_bit;
  logic [DATA_WIDTH-1:0] sr_data;
  logic                  sr_out;

  // Start is honoured only when idle and never in the done cycle
  assign accept      = start_i && !done_q && ((state_q == IDLE) || (state_q == IDLE_HELD));
  assign lead_tick   = clk_en_i && (state_q == SHIFT) && !phase_q;
  assign trail_tick  = clk_en_i && (state_q == SHIFT) && phase_q;
  assign last_trail  = trail_tick && (cnt_q == LAST_CNT);
  assign sample_tick = CPHA ? trail_tick : lead_tick;
  // The trailing edge after the last sample has no further bit to present
  assign drive_tick  = CPHA ? lead_tick : (trail_tick && !last_trail);
  assign first_bit   = MSB_FIRST ? tx_data_i[DATA_WIDTH-1] : tx_data_i[0];

  // One register carries tx bits out and collects rx bits in
  spi_shifter #(
    .WIDTH      (DATA_WIDTH),
    .SHIFT_LEFT (MSB_FIRST)
  ) u_shifter (
    .clk         (clk),
    .rst         (rst),
    .load_i      (accept),
    .load_data_i (tx_data_i),
    .shift_i     (sample_tick),
    .shift_in_i  (miso_i),
    .data_o      (sr_data),
    .shift_out_o (sr_out)
  );

  // Transfer sequencer with registered SPI and handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sclk_q    <= CPOL;
      cs_n_q    <= 1'b1;
      mosi_q    <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      phase_q   <= 1'b0;
      cnt_q     <= '0;
      rx_data_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (sample_tick) begin
        cnt_q <= cnt_q + CW'(1);
      end
      if (drive_tick) begin
        mosi_q <= sr_out;
      end
      case (state_q)
        IDLE, IDLE_HELD: begin
          busy_q <= 1'b0;
          if (accept) begin
            cs_n_q  <= 1'b0;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            phase_q <= 1'b0;
            if (!CPHA) begin
              mosi_q <= first_bit;
            end
            // cs_n is already low when held, so setup time is already met
            state_q <= (state_q == IDLE_HELD) ? SHIFT : SETUP;
          end
`ifdef SPI_XFER_CS_HOLD_EN
          else if ((state_q == IDLE_HELD) && clk_en_i && !cs_hold_i) begin
            cs_n_q  <= 1'b1;
            state_q <= IDLE;
          end
`endif
        end
        SETUP: begin
          if (clk_en_i) begin
            phase_q <= 1'b0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (clk_en_i) begin
            sclk_q  <= ~sclk_q;
            phase_q <= ~phase_q;
            if (last_trail) begin
              state_q <= HOLD;
            end
          end
        end
        HOLD: begin
          if (clk_en_i) begin
            done_q    <= 1'b1;
            rx_data_q <= sr_data;
            mosi_q    <= 1'b0;
`ifdef SPI_XFER_CS_HOLD_EN
            if (cs_hold_i) begin
              state_q <= IDLE_HELD;
            end else begin
              cs_n_q  <= 1'b1;
              state_q <= IDLE;
            end
`else
            cs_n_q  <= 1'b1;
            state_q <= IDLE;
`endif
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rx_data_o = rx_data_q;
  assign done_o    = done_q;
  assign busy_o    = busy_q;
  assign sclk_o    = sclk_q;
  assign mosi_o    = mosi_q;
  assign cs_n_o    = cs_n_q;

endmodule
`default_nettype wire
